// File: rtl/spike_pattern_decoder.sv
// Frames a serial spike stream into patterns using idle gaps and rebuilds each
// pattern as a slot bit-vector, one slot per spike-delay period.
module spike_pattern_decoder #(
   parameter int unsigned p_spike_delay = 5,
   parameter int unsigned p_gap_thresh  = 50,
   parameter int unsigned p_slots       = 16,
   parameter int unsigned p_cnt_w       = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_spike,
   input  logic               i_label,
   input  logic               i_end_of_epochs,
   output logic               o_valid,
   output logic [p_slots-1:0] o_pattern,
   output logic               o_label,
   output logic               o_overflow,
   output logic [p_cnt_w-1:0] o_pattern_count,
   output logic               o_busy,
   output logic               o_done
);

   localparam int unsigned CycW  = (p_spike_delay > 2) ? $clog2(p_spike_delay) : 1;
   localparam int unsigned SlotW = $clog2(p_slots + 1);
   localparam int unsigned IdxW  = (p_slots > 1) ? $clog2(p_slots) : 1;
   localparam int unsigned IdleW = $clog2(p_gap_thresh + 1);

   typedef enum logic [1:0] {StIdle, StCapture, StEmit} state_e;

   state_e state_q, state_d;

   logic [CycW-1:0]    cyc_q, cyc_d;
   logic [SlotW-1:0]   slot_q, slot_d;
   logic [IdxW-1:0]    slot_idx;
   logic [IdleW-1:0]   idle_q, idle_d;
   logic [p_slots-1:0] work_q, work_d;
   logic               wlabel_q, wlabel_d;
   logic               wovf_q, wovf_d;
   logic               gap_hit;

   logic               valid_d;
   logic [p_slots-1:0] pattern_d;
   logic               label_d;
   logic               overflow_d;
   logic [p_cnt_w-1:0] count_d;
   logic               done_d;

   // State register together with the datapath and registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q         <= StIdle;
         cyc_q           <= '0;
         slot_q          <= '0;
         idle_q          <= '0;
         work_q          <= '0;
         wlabel_q        <= 1'b0;
         wovf_q          <= 1'b0;
         o_valid         <= 1'b0;
         o_pattern       <= '0;
         o_label         <= 1'b0;
         o_overflow      <= 1'b0;
         o_pattern_count <= '0;
         o_busy          <= 1'b0;
         o_done          <= 1'b0;
      end else begin
         state_q         <= state_d;
         cyc_q           <= cyc_d;
         slot_q          <= slot_d;
         idle_q          <= idle_d;
         work_q          <= work_d;
         wlabel_q        <= wlabel_d;
         wovf_q          <= wovf_d;
         o_valid         <= valid_d;
         o_pattern       <= pattern_d;
         o_label         <= label_d;
         o_overflow      <= overflow_d;
         o_pattern_count <= count_d;
         o_busy          <= (state_d != StIdle);
         o_done          <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (i_spike) state_d = StCapture;
         StCapture: if (gap_hit) state_d = StEmit;
         StEmit:    state_d = i_spike ? StCapture : StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      cyc_d      = cyc_q;
      slot_d     = slot_q;
      slot_idx   = '0;
      idle_d     = idle_q;
      work_d     = work_q;
      wlabel_d   = wlabel_q;
      wovf_d     = wovf_q;
      gap_hit    = 1'b0;
      valid_d    = 1'b0;
      pattern_d  = o_pattern;
      label_d    = o_label;
      overflow_d = o_overflow;
      count_d    = o_pattern_count;
      done_d     = o_done | (i_end_of_epochs && (state_q == StIdle));

      // A spike in IDLE or in the EMIT cycle opens a fresh pattern in slot 0
      if ((state_q != StCapture) && i_spike) begin
         work_d   = {{(p_slots-1){1'b0}}, 1'b1};
         slot_d   = '0;
         cyc_d    = CycW'(1);
         idle_d   = '0;
         wlabel_d = i_label;
         wovf_d   = 1'b0;
      end else if (state_q == StCapture) begin
         if (cyc_q == CycW'(p_spike_delay - 1)) begin
            cyc_d = '0;
            if (slot_q != SlotW'(p_slots)) slot_d = slot_q + SlotW'(1);
         end else begin
            cyc_d = cyc_q + CycW'(1);
         end
         slot_idx = IdxW'(slot_d);
         if (i_spike) begin
            idle_d = '0;
            if (slot_d < SlotW'(p_slots)) work_d[slot_idx] = 1'b1;
            else                          wovf_d = 1'b1;
         end else begin
            idle_d = idle_q + IdleW'(1);
         end
         wlabel_d = wlabel_q | i_label;
         gap_hit  = (idle_d == IdleW'(p_gap_thresh));
         if (gap_hit) begin
            valid_d    = 1'b1;
            pattern_d  = work_d;
            label_d    = wlabel_d;
            overflow_d = wovf_d;
            count_d    = o_pattern_count + p_cnt_w'(1);
         end
      end
   end

endmodule

// File: tb/tb_spike_pattern_decoder.sv
// Random and directed stimulus for spike_pattern_decoder, checked every cycle
// against a spike-timestamp model of pattern framing and slot placement.
module tb_spike_pattern_decoder;

   localparam int D   = 5;
   localparam int GAP = 50;
   localparam int P   = 16;
   localparam int CW  = 16;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_spike = 1'b0;
   logic          i_label = 1'b0;
   logic          i_end_of_epochs = 1'b0;
   logic          o_valid;
   logic [P-1:0]  o_pattern;
   logic          o_label;
   logic          o_overflow;
   logic [CW-1:0] o_pattern_count;
   logic          o_busy;
   logic          o_done;

   spike_pattern_decoder #(
      .p_spike_delay(D),
      .p_gap_thresh (GAP),
      .p_slots      (P),
      .p_cnt_w      (CW)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_spike        (i_spike),
      .i_label        (i_label),
      .i_end_of_epochs(i_end_of_epochs),
      .o_valid        (o_valid),
      .o_pattern      (o_pattern),
      .o_label        (o_label),
      .o_overflow     (o_overflow),
      .o_pattern_count(o_pattern_count),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int nv    = 0;
   int tv    = 0;
   logic chk_on = 1'b0;
   logic eoe_lvl = 1'b0;

   // Model: expected outputs, plus a pattern described by its spike timestamps
   logic          exp_valid, exp_label, exp_ovf, exp_busy, exp_done;
   logic [P-1:0]  exp_pattern;
   logic [CW-1:0] exp_count;
   logic          m_active, m_emit, m_lab;
   int            t_start, t_last;
   int            spk_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      exp_valid = 0; exp_label = 0; exp_ovf = 0; exp_busy = 0; exp_done = 0;
      exp_pattern = '0; exp_count = '0;
      m_active = 0; m_emit = 0; m_lab = 0;
      spk_q.delete();
   endtask

   task automatic model_step(input logic spike, input logic label, input logic eoe);
      logic emit_n;
      int   s;
      emit_n = 1'b0;
      exp_valid = 1'b0;
      if (eoe && !m_active && !m_emit) exp_done = 1'b1;
      if (m_active) begin
         m_lab = m_lab | label;
         if (spike) begin
            spk_q.push_back(cyc);
            t_last = cyc;
         end else if (cyc - t_last == GAP) begin
            exp_pattern = '0;
            exp_ovf = 1'b0;
            foreach (spk_q[i]) begin
               s = (spk_q[i] - t_start + 1) / D;
               if (s >= P) exp_ovf = 1'b1;
               else exp_pattern[s] = 1'b1;
            end
            exp_label = m_lab;
            exp_valid = 1'b1;
            exp_count = exp_count + 1'b1;
            m_active = 1'b0;
            emit_n = 1'b1;
         end
      end else if (spike) begin
         m_active = 1'b1;
         t_start = cyc;
         t_last = cyc;
         spk_q.delete();
         spk_q.push_back(cyc);
         m_lab = label;
      end
      m_emit = emit_n;
      exp_busy = m_active || m_emit;
   endtask

   always @(negedge i_clk) begin
      if (chk_on) begin
         check("valid",    {31'b0, o_valid},    {31'b0, exp_valid});
         check("pattern",  {16'b0, o_pattern},  {16'b0, exp_pattern});
         check("label",    {31'b0, o_label},    {31'b0, exp_label});
         check("overflow", {31'b0, o_overflow}, {31'b0, exp_ovf});
         check("count",    {16'b0, o_pattern_count}, {16'b0, exp_count});
         check("busy",     {31'b0, o_busy},     {31'b0, exp_busy});
         check("done",     {31'b0, o_done},     {31'b0, exp_done});
      end
   end

   task automatic cycle(input logic rst, input logic spike, input logic label);
      i_rst = rst;
      i_spike = spike;
      i_label = label;
      i_end_of_epochs = eoe_lvl;
      if (rst) model_reset();
      @(posedge i_clk);
      if (rst) model_reset();
      else model_step(spike, label, eoe_lvl);
      cyc++;
      #1;
      if (o_valid) begin
         nv++;
         tv = cyc;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic play(input logic [99:0] mask, input int len, input logic lab0);
      for (int k = 0; k < len; k++) cycle(1'b0, mask[k], lab0 && (k == 0));
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      nv = 0;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 100 && !o_valid; i++) cycle(1'b0, 1'b0, 1'b0);
      check("valid_wait", {31'b0, o_valid}, 32'd1);
   endtask

   initial begin
      logic [99:0] m;
      int t0;
      int rate;
      model_reset();
      #1;
      chk_on = 1'b1;

      // Reset held with random spikes
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rst_outputs", {8'b0, o_valid, o_pattern, o_label, o_overflow, o_busy, o_done,
                            o_pattern_count[1:0]}, 32'd0);
      idle(1);
      check("rst_busy", {31'b0, o_busy}, 32'd0);
      nv = 0;

      // Single pattern: spikes at t0, t0+5, t0+15 with label
      t0 = cyc;
      m = 100'b1 | (100'b1 << 5) | (100'b1 << 15);
      play(m, 16, 1'b1);
      idle(60);
      check("single_npulse", nv, 1);
      check("single_latency", tv, t0 + 66);
      check("single_pattern", {16'b0, o_pattern}, 32'h000B);
      check("single_label", {31'b0, o_label}, 32'd1);
      check("single_count", {16'b0, o_pattern_count}, 32'd1);

      // Two patterns separated by 100 idle cycles
      do_reset();
      m = 100'b1 | (100'b1 << 5);
      play(m, 6, 1'b0);
      idle(100);
      play(m, 6, 1'b0);
      idle(60);
      check("gap_npulse", nv, 2);
      check("gap_pattern", {16'b0, o_pattern}, 32'h0003);
      check("gap_count", {16'b0, o_pattern_count}, 32'd2);

      // 40-cycle gap merges into one pattern: spikes at 0,5,46,51
      do_reset();
      m = 100'b1 | (100'b1 << 5) | (100'b1 << 46) | (100'b1 << 51);
      play(m, 52, 1'b0);
      idle(60);
      check("merge_npulse", nv, 1);
      check("merge_pattern", {16'b0, o_pattern}, 32'h0603);

      // Overflow: 18 spikes every 5 cycles, then a clean pattern
      do_reset();
      m = '0;
      for (int k = 0; k < 18; k++) m = m | (100'b1 << (5 * k));
      play(m, 86, 1'b0);
      idle(60);
      check("ovf_pattern", {16'b0, o_pattern}, 32'hFFFF);
      check("ovf_flag", {31'b0, o_overflow}, 32'd1);
      m = 100'b1 | (100'b1 << 5);
      play(m, 6, 1'b0);
      idle(60);
      check("ovf_clear", {31'b0, o_overflow}, 32'd0);

      // Spike landing in the EMIT cycle opens the next pattern
      do_reset();
      play(100'b1, 1, 1'b0);
      wait_valid();
      check("emit_first", {16'b0, o_pattern}, 32'h0001);
      cycle(1'b0, 1'b1, 1'b0);
      play(100'b1 << 4, 5, 1'b0);
      idle(60);
      check("emit_npulse", nv, 2);
      check("emit_pattern", {16'b0, o_pattern}, 32'h0003);

      // End of epochs raised mid-capture
      do_reset();
      play(100'b1, 1, 1'b0);
      idle(10);
      eoe_lvl = 1'b1;
      wait_valid();
      check("eoe_pending", {31'b0, o_done}, 32'd0);
      idle(2);
      check("eoe_done", {31'b0, o_done}, 32'd1);
      m = 100'b1 | (100'b1 << 5);
      play(m, 6, 1'b0);
      idle(60);
      check("eoe_after_pat", {16'b0, o_pattern}, 32'h0003);
      check("eoe_sticky", {31'b0, o_done}, 32'd1);
      eoe_lvl = 1'b0;

      // Reset mid-capture discards the partial pattern
      do_reset();
      play(100'b1, 1, 1'b1);
      idle(10);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      idle(80);
      check("midrst_npulse", nv, 0);
      check("midrst_count", {16'b0, o_pattern_count}, 32'd0);
      check("midrst_done", {31'b0, o_done}, 32'd0);

      // Random traffic with varying spike density
      do_reset();
      rate = 5;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) begin
            case ($urandom_range(0, 3))
               0: rate = 0;
               1: rate = 2;
               2: rate = 10;
               default: rate = 40;
            endcase
         end
         if (i == 2600) eoe_lvl = 1'b1;
         cycle(1'b0, 1'($urandom_range(0, 99) < rate), 1'($urandom_range(0, 9) == 0));
      end
      idle(60);

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
